// File: rtl/pairwise_gates_pkg.sv
// Shared types for the pairwise-gate datapath: per-transaction operation code
// and the popcount width helper used to size count ports.
package pairwise_gates_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XNOR = 2'd2,
        OP_XOR  = 2'd3
    } op_t;

    // Bits needed to hold a count from 0 up to nbits inclusive.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/pairwise_gates_comb.sv
// Gates each bit with its upper neighbour (optionally wrapping the top bit to bit 0)
// and counts the ones in the result; purely combinational, no flow control.
module pairwise_gates_comb
    import pairwise_gates_pkg::*;
#(
    parameter int  NBITS = 100,
    parameter int  WRAP  = 0,
    localparam int CW    = cnt_width(NBITS)
) (
    input  logic [NBITS-1:0] word_i,
    input  op_t              op_i,
    output logic [NBITS-1:0] result_o,
    output logic [CW-1:0]    count_o
);

    logic [NBITS-1:0] partner;
    logic [NBITS-1:0] gated;
    logic [CW-1:0]    ones;

    // partner[i] = word_i[i+1]; the top position sees bit 0 and is masked when linear.
    assign partner = {word_i[0], word_i[NBITS-1:1]};

    always_comb begin
        gated = '0;
        case (op_i)
            OP_AND:  gated = word_i & partner;
            OP_OR:   gated = word_i | partner;
            OP_XNOR: gated = ~(word_i ^ partner);
            OP_XOR:  gated = word_i ^ partner;
            default: gated = '0;
        endcase
        if (WRAP == 0) begin
            gated[NBITS-1] = 1'b0;
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < NBITS; i++) begin
            ones = ones + CW'(gated[i]);
        end
    end

    assign result_o = gated;
    assign count_o  = ones;

endmodule

// File: rtl/pairwise_gates_pipe.sv
// Two-stage valid/ready wrapper around pairwise_gates_comb; result visible two cycles after accept.
// Full backpressure: a stalled output holds all stages, and in_rdy follows out_rdy combinationally.
module pairwise_gates_pipe
    import pairwise_gates_pkg::*;
#(
    parameter int  NBITS = 100,
    parameter int  WRAP  = 0,
    localparam int CW    = cnt_width(NBITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_,
    input  logic [1:0]       in_op,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_,
    output logic [1:0]       out_op,
    output logic [CW-1:0]    out_count
);

    logic             s1_val_q, s1_val_d;
    logic [NBITS-1:0] s1_word_q, s1_word_d;
    op_t              s1_op_q, s1_op_d;

    logic             s2_val_q, s2_val_d;
    logic [NBITS-1:0] s2_res_q, s2_res_d;
    op_t              s2_op_q, s2_op_d;
    logic [CW-1:0]    s2_cnt_q, s2_cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [NBITS-1:0] comb_res;
    logic [CW-1:0]    comb_cnt;

    assign s2_adv = !s2_val_q || out_rdy;
    assign s1_adv = !s1_val_q || s2_adv;
    assign in_rdy = s1_adv && reset_n;

    pairwise_gates_comb #(
        .NBITS (NBITS),
        .WRAP  (WRAP)
    ) u_comb (
        .word_i   (s1_word_q),
        .op_i     (s1_op_q),
        .result_o (comb_res),
        .count_o  (comb_cnt)
    );

    // Data registers only load on a real transfer; an idle slot keeps stale don't-care data.
    always_comb begin
        s1_val_d  = s1_val_q;
        s1_word_d = s1_word_q;
        s1_op_d   = s1_op_q;
        if (s1_adv) begin
            s1_val_d = in_val;
            if (in_val) begin
                s1_word_d = in_;
                s1_op_d   = op_t'(in_op);
            end
        end
    end

    always_comb begin
        s2_val_d = s2_val_q;
        s2_res_d = s2_res_q;
        s2_op_d  = s2_op_q;
        s2_cnt_d = s2_cnt_q;
        if (s2_adv) begin
            s2_val_d = s1_val_q;
            if (s1_val_q) begin
                s2_res_d = comb_res;
                s2_op_d  = s1_op_q;
                s2_cnt_d = comb_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_val_q  <= 1'b0;
            s1_word_q <= '0;
            s1_op_q   <= OP_AND;
            s2_val_q  <= 1'b0;
            s2_res_q  <= '0;
            s2_op_q   <= OP_AND;
            s2_cnt_q  <= '0;
        end else begin
            s1_val_q  <= s1_val_d;
            s1_word_q <= s1_word_d;
            s1_op_q   <= s1_op_d;
            s2_val_q  <= s2_val_d;
            s2_res_q  <= s2_res_d;
            s2_op_q   <= s2_op_d;
            s2_cnt_q  <= s2_cnt_d;
        end
    end

    assign out_val   = s2_val_q;
    assign out_      = s2_res_q;
    assign out_op    = s2_op_q;
    assign out_count = s2_cnt_q;

endmodule

// File: tb/tb_pairwise_gates_pipe.sv
// Bench for pairwise_gates_pipe: a linear (WRAP=0) and a circular (WRAP=1) 8-bit
// instance share one stimulus stream; each has its own scoreboard queue.
module tb_pairwise_gates_pipe;

    logic       clk;
    logic       reset_n;
    logic       in_val;
    logic [7:0] in_;
    logic [1:0] in_op;
    logic       out_rdy;

    logic       in_rdy0, out_val0, in_rdy1, out_val1;
    logic [7:0] out0, out1;
    logic [1:0] op0, op1;
    logic [3:0] cnt0, cnt1;

    pairwise_gates_pipe #(.NBITS(8), .WRAP(0)) u_lin (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy0), .in_(in_), .in_op(in_op),
        .out_val(out_val0), .out_rdy(out_rdy), .out_(out0), .out_op(op0), .out_count(cnt0)
    );

    pairwise_gates_pipe #(.NBITS(8), .WRAP(1)) u_circ (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy1), .in_(in_), .in_op(in_op),
        .out_val(out_val1), .out_rdy(out_rdy), .out_(out1), .out_op(op1), .out_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] w;
        logic [1:0] op;
    } pkt_t;

    typedef struct {
        logic [7:0] w;
        logic [1:0] op;
        logic [7:0] e0;
        logic [3:0] c0;
        logic [7:0] e1;
        logic [3:0] c1;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   nd0   = 0;
    int   nd1   = 0;
    bit   last_acc = 0;
    bit   hold_pend = 0;
    logic [7:0] hold_w;
    logic [3:0] hold_c;
    logic [1:0] hold_op;
    pkt_t q0[$];
    pkt_t q1[$];
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: pair i is (w[i], w[i+1 mod 8]); the top pair exists only when wrapping.
    function automatic logic [7:0] model(input logic [7:0] w, input logic [1:0] op, input bit wrap);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int a;
            int b;
            a = int'(w[i]);
            b = int'(w[(i + 1) % 8]);
            case (op)
                2'd0:    r[i] = (a * b) == 1;
                2'd1:    r[i] = (a + b) > 0;
                2'd2:    r[i] = (a == b);
                default: r[i] = (a != b);
            endcase
            if (i == 7 && !wrap) r[i] = 1'b0;
        end
        return r;
    endfunction

    // Called at a negedge with inputs already driven; observes the coming edge's
    // transfers, scores deliveries, then advances to the next negedge.
    task automatic tick();
        pkt_t p;
        logic [7:0] e;
        #1;
        if (hold_pend) begin
            check("hold_out", out0, hold_w);
            check("hold_cnt", cnt0, hold_c);
            check("hold_op", op0, hold_op);
        end
        last_acc = in_val && in_rdy0;
        if (in_val && in_rdy0) q0.push_back('{in_, in_op});
        if (in_val && in_rdy1) q1.push_back('{in_, in_op});
        if (out_val0 && out_rdy) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_lin: got %0h want no output", out0);
            end else begin
                p = q0.pop_front();
                e = model(p.w, p.op, 1'b0);
                check("lin_res", out0, e);
                check("lin_cnt", cnt0, 32'($countones(e)));
                check("lin_op", op0, p.op);
            end
            nd0++;
        end
        if (out_val1 && out_rdy) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_circ: got %0h want no output", out1);
            end else begin
                p = q1.pop_front();
                e = model(p.w, p.op, 1'b1);
                check("circ_res", out1, e);
                check("circ_cnt", cnt1, 32'($countones(e)));
                check("circ_op", op1, p.op);
            end
            nd1++;
        end
        hold_pend = out_val0 && !out_rdy;
        hold_w  = out0;
        hold_c  = cnt0;
        hold_op = op0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        pkt_t bp[4];
        int   sent;
        int   base;

        reset_n = 1'b0; in_val = 1'b0; in_ = '0; in_op = '0; out_rdy = 1'b0;

        tbl[0] = '{8'hB6, 2'd0, 8'h12, 4'd2, 8'h12, 4'd2};
        tbl[1] = '{8'hB6, 2'd2, 8'h12, 4'd2, 8'h12, 4'd2};
        tbl[2] = '{8'hB6, 2'd1, 8'h7F, 4'd7, 8'hFF, 4'd8};
        tbl[3] = '{8'hB6, 2'd3, 8'h6D, 4'd5, 8'hED, 4'd6};
        tbl[4] = '{8'hFF, 2'd0, 8'h7F, 4'd7, 8'hFF, 4'd8};
        tbl[5] = '{8'h00, 2'd2, 8'h7F, 4'd7, 8'hFF, 4'd8};
        tbl[6] = '{8'h00, 2'd3, 8'h00, 4'd0, 8'h00, 4'd0};

        repeat (2) @(negedge clk);
        check("rst_val", out_val0, 0);
        check("rst_out", out0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_op", op0, 0);
        check("rst_rdy", in_rdy0, 0);
        check("rst_val_circ", out_val1, 0);
        reset_n = 1'b1;
        #1;
        check("rdy_after_rst", in_rdy0, 1);
        @(negedge clk);

        // Directed vectors: accept, one edge in S1, then visible for exactly one cycle.
        for (int k = 0; k < 7; k++) begin
            in_val = 1'b1; in_ = tbl[k].w; in_op = tbl[k].op; out_rdy = 1'b1;
            tick();
            in_val = 1'b0;
            check("lat_not_early", out_val0, 0);
            tick();
            check("lat_val", out_val0, 1);
            check("vec_lin_res", out0, tbl[k].e0);
            check("vec_lin_cnt", cnt0, tbl[k].c0);
            check("vec_circ_res", out1, tbl[k].e1);
            check("vec_circ_cnt", cnt1, tbl[k].c1);
            check("vec_op", op0, tbl[k].op);
            tick();
            check("single_pulse", out_val0, 0);
        end

        // Backpressure: four words against a stalled consumer, then release.
        bp[0] = '{8'hB6, 2'd0}; bp[1] = '{8'h3C, 2'd1};
        bp[2] = '{8'hFF, 2'd3}; bp[3] = '{8'h81, 2'd2};
        out_rdy = 1'b0; sent = 0; base = nd0;
        for (int c = 0; c < 8; c++) begin
            in_val = 1'b1; in_ = bp[sent].w; in_op = bp[sent].op;
            tick();
            if (last_acc) sent++;
        end
        check("bp_accepts", sent, 2);
        check("bp_rdy_low", in_rdy0, 0);
        check("bp_val_held", out_val0, 1);
        check("bp_first_res", out0, model(bp[0].w, bp[0].op, 1'b0));
        out_rdy = 1'b1;
        #1;
        check("bp_rdy_comb", in_rdy0, 1);
        for (int c = 0; c < 20 && !(sent == 4 && q0.size() == 0); c++) begin
            if (sent < 4) begin
                in_val = 1'b1; in_ = bp[sent].w; in_op = bp[sent].op;
            end else begin
                in_val = 1'b0;
            end
            tick();
            if (last_acc) sent++;
        end
        in_val = 1'b0;
        check("bp_sent", sent, 4);
        check("bp_delivered", nd0 - base, 4);

        // Reset with two words in flight.
        out_rdy = 1'b0;
        in_val = 1'b1; in_ = 8'hB6; in_op = 2'd3; tick();
        in_val = 1'b1; in_ = 8'h5A; in_op = 2'd1; tick();
        check("mid_val_before", out_val0, 1);
        in_val = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_val", out_val0, 0);
        check("mid_rst_out", out0, 0);
        check("mid_rst_cnt", cnt0, 0);
        check("mid_rst_val_circ", out_val1, 0);
        q0.delete(); q1.delete(); hold_pend = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; out_rdy = 1'b1;
        #1;
        check("mid_rdy_after", in_rdy0, 1);
        @(negedge clk);
        base = nd0;
        repeat (5) tick();
        check("no_stale", nd0 - base, 0);

        // Random valid/ready traffic; the producer holds a word until it is taken.
        sent = 0; base = nd0; in_val = 1'b0; last_acc = 0;
        for (int c = 0; c < 20000 && (nd0 - base) < 1000; c++) begin
            if (!(in_val && !last_acc)) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    in_val = 1'b1; in_ = 8'($urandom); in_op = 2'($urandom);
                end else begin
                    in_val = 1'b0;
                end
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) sent++;
        end
        in_val = 1'b0;
        check("rand_sent", sent, 1000);
        check("rand_delivered", nd0 - base, 1000);
        check("rand_q_lin", q0.size(), 0);
        check("rand_q_circ", q1.size(), 0);
        check("rand_count_match", nd1, nd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
